// File: rtl/window_ctrl.sv
// 3x3 sliding-window controller over four rotating line buffers.
// Lines are written in raster order; a window row of three lines is read out once three full lines are buffered.

module line_buffer #(
  parameter int SIZE  = 8,
  parameter int IMG_W = 512
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [SIZE-1:0]     i_data,
  input  logic                i_data_valid,
  output logic [3*SIZE-1:0]   o_data,
  input  logic                i_rd_data
);
  localparam int PW = $clog2(IMG_W);
  localparam logic [PW-1:0] LAST = PW'(IMG_W - 1);

  logic [SIZE-1:0] line_mem [IMG_W];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr1;
  logic [PW-1:0]   rd_ptr2;

  // Neighbour column index, pinned to the last column for right-border replication
  function automatic logic [PW-1:0] clamp_next(input logic [PW-1:0] p);
    return (p == LAST) ? LAST : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_data_valid)
      line_mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_data_valid)
        wr_ptr <= wr_ptr + PW'(1);
      if (i_rd_data)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_comb begin
    rd_ptr1 = clamp_next(rd_ptr);
    rd_ptr2 = clamp_next(rd_ptr1);
    o_data  = {line_mem[rd_ptr], line_mem[rd_ptr1], line_mem[rd_ptr2]};
  end
endmodule

module window_ctrl #(
  parameter int SIZE  = 8,
  parameter int IMG_W = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE-1:0]     i_pixel_data,
  input  logic                i_pixel_data_valid,
  output logic [9*SIZE-1:0]   o_pixel_data,
  output logic                o_pixel_data_valid,
  output logic                o_intr,
  output logic                o_overflow
);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(4 * IMG_W) + 1;
  localparam logic [CW-1:0] LAST  = CW'(IMG_W - 1);
  localparam logic [FW-1:0] FILL3 = FW'(3 * IMG_W);
  localparam logic [FW-1:0] FILL4 = FW'(4 * IMG_W);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic [1:0]        wr_sel;
  logic [1:0]        rd_sel;
  logic [FW-1:0]     fill;
  logic              rd_active;
  logic              rd_done;
  logic [3:0]        lb_wr_en;
  logic [3:0]        lb_rd_en;
  logic [3*SIZE-1:0] lb_data [4];

  // Occupancy update; a write into a completely full set of lines is still performed but the count holds
  function automatic logic [FW-1:0] fill_update(input logic [FW-1:0] f,
                                                input logic wr, input logic rd);
    if (wr && !rd)
      return (f == FILL4) ? f : f + FW'(1);
    else if (rd && !wr)
      return f - FW'(1);
    else
      return f;
  endfunction

  assign rd_active = (state == READ);

  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    case (state)
      IDLE: if (fill >= FILL3) state_nxt = READ;
      READ: if (rd_cnt == LAST) begin
        state_nxt = IDLE;
        rd_done   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      wr_sel     <= '0;
      rd_cnt     <= '0;
      rd_sel     <= '0;
      fill       <= '0;
      o_intr     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_intr <= rd_done;
      fill   <= fill_update(fill, i_pixel_data_valid, rd_active);
      if (i_pixel_data_valid) begin
        wr_cnt <= wr_cnt + CW'(1);
        if (wr_cnt == LAST)
          wr_sel <= wr_sel + 2'd1;
      end
      if (rd_active) begin
        rd_cnt <= rd_done ? '0 : rd_cnt + CW'(1);
        if (rd_done)
          rd_sel <= rd_sel + 2'd1;
      end
      if (i_pixel_data_valid && !rd_active && fill == FILL4)
        o_overflow <= 1'b1;
    end
  end

  // The three lines being read are rd_sel..rd_sel+2; only the fourth (offset 3) is idle
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lb_wr_en[k] = i_pixel_data_valid && (wr_sel == 2'(k));
      lb_rd_en[k] = rd_active && ((2'(k) - rd_sel) != 2'd3);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lb
    line_buffer #(
      .SIZE  (SIZE),
      .IMG_W (IMG_W)
    ) u_lb (
      .clk          (clk),
      .rstN         (~rst),
      .i_data       (i_pixel_data),
      .i_data_valid (lb_wr_en[g]),
      .o_data       (lb_data[g]),
      .i_rd_data    (lb_rd_en[g])
    );
  end

  assign o_pixel_data_valid = rd_active;
  assign o_pixel_data = rd_active ?
                        {lb_data[rd_sel], lb_data[rd_sel + 2'd1], lb_data[rd_sel + 2'd2]} : '0;
endmodule

// File: tb/tb_window_ctrl.sv
// Randomized scoreboard bench for window_ctrl: a line-level image model predicts every 3x3 window.
// A negedge monitor pops and compares each presented window and tracks the end-of-line pulse.

module tb_window_ctrl;
  localparam int W    = 64;
  localparam int SIZE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [SIZE-1:0]   din;
  logic              din_vld;
  logic [9*SIZE-1:0] dout;
  logic              dout_vld;
  logic              intr;
  logic              ovf;

  int errors = 0;
  int checks = 0;

  logic [9*SIZE-1:0] expq [$];
  logic [SIZE-1:0]   mdl [8][W];
  int lines_done;
  int pix_in_line;
  int intr_seen;
  int col;
  bit pend_intr;
  bit mon_en;

  window_ctrl #(.SIZE(SIZE), .IMG_W(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_pixel_data       (din),
    .i_pixel_data_valid (din_vld),
    .o_pixel_data       (dout),
    .o_pixel_data_valid (dout_vld),
    .o_intr             (intr),
    .o_overflow         (ovf)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  function automatic int cl(input int c);
    return (c > W - 1) ? W - 1 : c;
  endfunction

  function automatic logic [3*SIZE-1:0] row(input int l, input int c);
    return {mdl[l % 8][c], mdl[l % 8][cl(c + 1)], mdl[l % 8][cl(c + 2)]};
  endfunction

  // Read r uses image lines r, r+1, r+2 (top to bottom) once line r+2 is complete
  function automatic void push_read(input int r);
    for (int c = 0; c < W; c++)
      expq.push_back({row(r, c), row(r + 1, c), row(r + 2, c)});
  endfunction

  task automatic write_px(input logic [SIZE-1:0] v);
    din     = v;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    mdl[lines_done % 8][pix_in_line] = v;
    pix_in_line++;
    if (pix_in_line == W) begin
      pix_in_line = 0;
      if (lines_done >= 2) push_read(lines_done - 2);
      lines_done++;
    end
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    din_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expq.delete();
    lines_done  = 0;
    pix_in_line = 0;
    intr_seen   = 0;
    col         = 0;
    pend_intr   = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic wait_intr(input int target, input string name);
    int b = 0;
    while (intr_seen < target && b < 5000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 5000) bound_fail(name);
  endtask

  always @(negedge clk) begin
    if (!rst && intr) intr_seen++;
  end

  always @(negedge clk) begin
    logic [71:0] e;
    if (!rst && mon_en) begin
      if (pend_intr || intr) check("intr_pulse", {71'd0, intr}, {71'd0, pend_intr});
      pend_intr = 1'b0;
      check("no_overflow", {71'd0, ovf}, 72'd0);
      if (dout_vld) begin
        if (expq.size() == 0) begin
          bound_fail("unexpected_window");
        end else begin
          e = expq.pop_front();
          check("window", dout, e);
        end
        col++;
        if (col == W) begin
          col       = 0;
          pend_intr = 1'b1;
        end
      end else begin
        check("idle_data_zero", dout, 72'd0);
        if (col != 0) begin
          bound_fail("valid_gap");
          col = 0;
        end
      end
    end
  end

  initial begin
    int b;
    int n;
    rst     = 1'b1;
    din     = '0;
    din_vld = 1'b0;
    mon_en  = 1'b1;
    do_reset();

    // Reset state
    check("reset_valid", {71'd0, dout_vld}, 72'd0);
    check("reset_intr", {71'd0, intr}, 72'd0);
    check("reset_ovf", {71'd0, ovf}, 72'd0);
    check("reset_data", dout, 72'd0);

    // First-read latency: nothing until pixel 3W, valid on the second edge after it
    for (int i = 0; i < 3 * W - 1; i++) write_px(SIZE'($urandom));
    idle(5);
    check("prefill_no_valid", {71'd0, dout_vld}, 72'd0);
    write_px(SIZE'($urandom));
    check("latency_edge1", {71'd0, dout_vld}, 72'd0);
    @(posedge clk);
    #1;
    check("latency_edge2", {71'd0, dout_vld}, 72'd1);
    wait_intr(1, "latency_intr");
    idle(3);

    // Constant lines: first window and right-border replicated window
    do_reset();
    for (int l = 1; l <= 3; l++)
      for (int i = 0; i < W; i++) write_px(SIZE'(l));
    b = 0;
    while (!dout_vld && b < 20) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("const_first", dout, 72'h01_01_01_02_02_02_03_03_03);
    repeat (W - 1) @(posedge clk);
    #1;
    check("const_last_valid", {71'd0, dout_vld}, 72'd1);
    check("const_last", dout, 72'h01_01_01_02_02_02_03_03_03);
    @(posedge clk);
    #1;
    check("const_end", {71'd0, dout_vld}, 72'd0);
    wait_intr(1, "const_intr");
    idle(3);

    // Random stream with gaps, writing up to four lines ahead of the reader
    do_reset();
    for (int l = 0; l < 12; l++) begin
      b = 0;
      while (l - intr_seen >= 4 && b < 5000) begin
        @(posedge clk);
        #1;
        b++;
      end
      if (b >= 5000) bound_fail("stream_flow");
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        write_px(SIZE'($urandom));
      end
    end
    wait_intr(10, "stream_intr");
    idle(6);
    check("stream_reads", 72'(intr_seen), 72'd10);
    check("stream_drained", 72'(expq.size()), 72'd0);
    check("stream_fill", 72'(dut.fill), 72'(2 * W));
    check("stream_rd_sel", 72'(dut.rd_sel), 72'(10 % 4));
    check("stream_idle", {71'd0, dout_vld}, 72'd0);

    // Overflow: continuous writes ignoring the line pulse
    do_reset();
    mon_en = 1'b0;
    n = 0;
    while (!ovf && n < 10000) begin
      din     = SIZE'($urandom);
      din_vld = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    din_vld = 1'b0;
    check("ovf_set", {71'd0, ovf}, 72'd1);
    check("ovf_not_early", {71'd0, (n > 4 * W)}, 72'd1);
    idle(50);
    check("ovf_sticky", {71'd0, ovf}, 72'd1);
    do_reset();
    check("ovf_cleared", {71'd0, ovf}, 72'd0);
    mon_en = 1'b1;

    // Reset in the middle of a read, then a fresh image from line 0
    for (int i = 0; i < 3 * W; i++) write_px(SIZE'($urandom));
    b = 0;
    while (!dout_vld && b < 20) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("midrst_started", {71'd0, dout_vld}, 72'd1);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid_drop", {71'd0, dout_vld}, 72'd0);
    check("midrst_data_zero", dout, 72'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_intr", {71'd0, intr}, 72'd0);
    end
    do_reset();
    for (int i = 0; i < 3 * W; i++) write_px(SIZE'($urandom));
    b = 0;
    while (!dout_vld && b < 20) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("fresh_rd_sel", 72'(dut.rd_sel), 72'd0);
    wait_intr(1, "fresh_intr");
    idle(4);
    check("fresh_drained", 72'(expq.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
